ras_ctrl: RTL and testbench
===========================

Name: ras_ctrl

Overview:
- Upstream control and data stage for ras_links.
- Converts fetch-side call/return events into incr/decr/gen_addr/set_addr commands for ras_links.
- Stores return-address data in an internal stack RAM indexed by the ras_links addr_out, and exposes the top of stack.
- Holds a ring of speculative checkpoints; a mispredict restore rewinds the stack pointer through set_addr.

Parameters:
- DEPTH, 1024, stack entries; must equal the DEPTH of the attached ras_links.
- WIDTH, 32, return-address data width.
- CKPT_DEPTH, 8, checkpoint slots; power of 2.
- ADDR (localparam), $clog2(DEPTH).
- CKID (localparam), $clog2(CKPT_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  call: push push_data.
- push_data  in  WIDTH  return address to store.
- pop  in  1  return: pop top of stack.
- ckpt_save  in  1  snapshot the post-operation stack state of this cycle.
- ckpt_id  out  CKID  slot written by the current ckpt_save.
- ckpt_restore  in  1  rewind to slot restore_id.
- restore_id  in  CKID  slot to restore.
- ready  out  1  push/pop/ckpt accepted this cycle.
- top_data  out  WIDTH  registered top-of-stack data.
- top_valid  out  1  stack non-empty.
- overflow  out  1  one-cycle pulse: push dropped.
- underflow  out  1  one-cycle pulse: pop on empty stack.
- links_incr, links_decr, links_gen_addr, links_set_addr  out  1 each  commands to ras_links.
- links_addr_in  out  ADDR  address for set_addr.
- links_addr  in  ADDR  ras_links addr_out (next current address, combinational).
- links_full  in  1  ras_links full.

Behaviour:
- Reset state (asynchronous, reset low):
  - state=INIT, count=0, ckpt write pointer=0, all checkpoint slots invalid.
  - top_valid=0, top_data=0, overflow=underflow=0, ready=0.
  - All links_* command outputs are 0 while reset is low.
- FSM states INIT, RUN:
  - INIT: first cycle after reset release. links_gen_addr=1, ready=0, then go to RUN.
  - RUN: ready=1. Stays in RUN.
  - A reset assertion in any state returns to INIT; in-flight requests are lost.
- Commands issued in RUN, with priority restore > push+pop > push > pop:
  - ckpt_restore:
    - links_set_addr=1 and links_addr_in=slot.addr; count<=slot.count.
    - push, pop and ckpt_save in the same cycle are ignored.
    - Restoring an invalid slot: links_set_addr=1 to address 0 and count<=0.
  - push and pop together: replace the top entry. No incr/decr; RAM write at links_addr; count unchanged. If count==0 this acts as a plain push.
  - push alone:
    - If count==DEPTH or links_full: dropped and overflow pulses.
    - Otherwise links_incr=1, RAM write of push_data at links_addr (the new current address, same cycle), count+1.
  - pop alone:
    - If count==0: no decr and underflow pulses.
    - Otherwise links_decr=1, count-1.
- Combinational outputs: links_incr, links_decr and links_set_addr are combinational from the inputs in the same cycle. None is asserted when ready=0.
- Stack RAM (DEPTH x WIDTH, single write port, synchronous read):
  - Read address = links_addr every cycle; top_data is valid the next cycle.
  - Write-first: a push at cycle T gives top_data=push_data at T+1.
- top_valid: registered, equals (count_next != 0).
- Checkpoints:
  - ckpt_save stores {links_addr, count_next} into slot wptr and marks it valid.
  - ckpt_id=wptr is presented in the same cycle; wptr then increments mod CKPT_DEPTH.
  - The oldest slot is overwritten silently on wrap.
- Restore semantics:
  - Data overwritten after a checkpoint is not recovered.
  - Only the pointer and count are restored; corrupted top data after restore is accepted behaviour.
- count width: ADDR+1 bits, range 0..DEPTH, saturating as specified above.

Test Plan:
- Reset release -> INIT for 1 cycle with links_gen_addr=1, then ready=1, top_valid=0, count=0.
- Push 0x100, 0x200, 0x300 on consecutive cycles -> top_data=0x300 the cycle after the last push. Then pop x3 -> top_data 0x200, then 0x100, then top_valid=0.
- Pop on empty stack -> underflow=1 for one cycle, links_decr=0, count stays 0.
- Push 0xA, then push 0xB with ckpt_save (ckpt_id=0), push 0xC, push 0xD, then restore_id=0 -> links_set_addr=1, count=2, top_data=0xB next cycle.
- Push and pop asserted together with 0x55 at count=3 -> no incr/decr, top_data=0x55, count stays 3.
- Fill to DEPTH (or hold links_full=1), then push -> overflow pulse, links_incr=0. Separately, assert reset mid-push -> all outputs 0 immediately and INIT on release.

Source files
------------

// File: rtl/ras_ctrl.sv
// Return-address-stack control stage: turns call/return events into ras_links commands,
// keeps the return-address RAM and a ring of speculative checkpoints for mispredict recovery.
module ras_ctrl #(
  parameter  int DEPTH      = 1024,
  parameter  int WIDTH      = 32,
  parameter  int CKPT_DEPTH = 8,
  localparam int ADDR       = $clog2(DEPTH),
  localparam int CKID       = $clog2(CKPT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             ckpt_save,
  output logic [CKID-1:0]  ckpt_id,
  input  logic             ckpt_restore,
  input  logic [CKID-1:0]  restore_id,
  output logic             ready,
  output logic [WIDTH-1:0] top_data,
  output logic             top_valid,
  output logic             overflow,
  output logic             underflow,
  output logic             links_incr,
  output logic             links_decr,
  output logic             links_gen_addr,
  output logic             links_set_addr,
  output logic [ADDR-1:0]  links_addr_in,
  input  logic [ADDR-1:0]  links_addr,
  input  logic             links_full,
  output logic             dbg_state
);

  // Handshake: every command input is taken in any cycle where ready=1; there is no
  // back-pressure beyond that, and requests seen while ready=0 are discarded.

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR:0] CNT_MAX = (ADDR+1)'(DEPTH);

  state_t          state, state_next;
  logic [ADDR:0]   count, count_next;
  logic [CKID-1:0] wptr;
  logic            ram_we;
  logic            save_en;
  logic            ovf_next, unf_next;

  logic [WIDTH-1:0] ram [DEPTH];

  logic [CKPT_DEPTH-1:0] ck_vld;
  logic [ADDR-1:0]       ck_addr [CKPT_DEPTH];
  logic [ADDR:0]         ck_cnt  [CKPT_DEPTH];

  assign ckpt_id   = wptr;
  assign dbg_state = state;

  always_comb begin
    state_next     = state;
    ready          = 1'b0;
    links_gen_addr = 1'b0;
    links_incr     = 1'b0;
    links_decr     = 1'b0;
    links_set_addr = 1'b0;
    links_addr_in  = '0;
    ram_we         = 1'b0;
    save_en        = 1'b0;
    ovf_next       = 1'b0;
    unf_next       = 1'b0;
    count_next     = count;
    case (state)
      S_INIT: begin
        // Gated by reset so no link command leaks out while reset is held.
        links_gen_addr = reset;
        state_next     = S_RUN;
      end
      S_RUN: begin
        ready = 1'b1;
        if (ckpt_restore) begin
          links_set_addr = 1'b1;
          if (ck_vld[restore_id]) begin
            links_addr_in = ck_addr[restore_id];
            count_next    = ck_cnt[restore_id];
          end else begin
            count_next = '0;
          end
        end else begin
          save_en = ckpt_save;
          if (push && pop && count != '0) begin
            ram_we = 1'b1;
          end else if (push) begin
            if (count == CNT_MAX || links_full) begin
              ovf_next = 1'b1;
            end else begin
              links_incr = 1'b1;
              ram_we     = 1'b1;
              count_next = count + 1'b1;
            end
          end else if (pop) begin
            if (count == '0) begin
              unf_next = 1'b1;
            end else begin
              links_decr = 1'b1;
              count_next = count - 1'b1;
            end
          end
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      count     <= '0;
      top_valid <= 1'b0;
      top_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      wptr      <= '0;
      ck_vld    <= '0;
      for (int i = 0; i < CKPT_DEPTH; i++) begin
        ck_addr[i] <= '0;
        ck_cnt[i]  <= '0;
      end
    end else begin
      state     <= state_next;
      count     <= count_next;
      top_valid <= (count_next != '0);
      overflow  <= ovf_next;
      underflow <= unf_next;
      // Read and write share links_addr, so write-first reduces to a bypass mux.
      top_data  <= ram_we ? push_data : ram[links_addr];
      if (save_en) begin
        ck_addr[wptr] <= links_addr;
        ck_cnt[wptr]  <= count_next;
        ck_vld[wptr]  <= 1'b1;
        wptr          <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[links_addr] <= push_data;
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: a small ras_links stand-in, a stack-level reference model compared
// every cycle, and directed vectors with hand-computed literal expectations.
module tb_ras_ctrl;
  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int CK    = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(CK);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, ckpt_save = 1'b0, ckpt_restore = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic [CW-1:0] restore_id = '0;
  logic [CW-1:0] ckpt_id;
  logic          ready, top_valid, overflow, underflow;
  logic [W-1:0]  top_data;
  logic          links_incr, links_decr, links_gen_addr, links_set_addr;
  logic [AW-1:0] links_addr_in, links_addr;
  logic          links_full = 1'b0;
  logic          dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(W), .CKPT_DEPTH(CK)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .ckpt_restore(ckpt_restore),
    .restore_id(restore_id), .ready(ready), .top_data(top_data), .top_valid(top_valid),
    .overflow(overflow), .underflow(underflow), .links_incr(links_incr),
    .links_decr(links_decr), .links_gen_addr(links_gen_addr),
    .links_set_addr(links_set_addr), .links_addr_in(links_addr_in),
    .links_addr(links_addr), .links_full(links_full), .dbg_state(dbg_state)
  );

  // ras_links stand-in: current pointer, addr_out shows the post-command address.
  logic [AW-1:0] cur;
  always_comb begin
    links_addr = cur;
    if (links_gen_addr)      links_addr = '0;
    else if (links_set_addr) links_addr = links_addr_in;
    else if (links_incr)     links_addr = cur + 1'b1;
    else if (links_decr)     links_addr = cur - 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cur <= '0; else cur <= links_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a stack of entries at abstract positions, count, checkpoint ring.
  typedef enum {K_NONE, K_REST, K_REPL, K_PUSH, K_OVF, K_POP, K_UNF} kind_t;
  bit           m_run;
  int           m_sp, m_cnt, m_wptr;
  logic [W-1:0] m_mem [DEPTH];
  bit           m_ckv [CK];
  int           m_cka [CK];
  int           m_ckc [CK];
  logic [W-1:0] m_top;
  bit           m_tv, m_ovf, m_unf;

  function automatic kind_t kind_of();
    if (!m_run) return K_NONE;
    if (ckpt_restore) return K_REST;
    if (push && pop && m_cnt > 0) return K_REPL;
    if (push) return (m_cnt == DEPTH || links_full) ? K_OVF : K_PUSH;
    if (pop) return (m_cnt == 0) ? K_UNF : K_POP;
    return K_NONE;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_sp = 0; m_cnt = 0; m_wptr = 0;
      m_top = '0; m_tv = 0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < CK; i++) m_ckv[i] = 0;
    end else begin
      kind_t k;
      k = kind_of();
      if (!m_run) m_sp = 0;
      case (k)
        K_REST: begin
          m_sp  = m_ckv[restore_id] ? m_cka[restore_id] : 0;
          m_cnt = m_ckv[restore_id] ? m_ckc[restore_id] : 0;
        end
        K_PUSH: begin m_sp = (m_sp + 1) % DEPTH; m_cnt++; end
        K_POP:  begin m_sp = (m_sp + DEPTH - 1) % DEPTH; m_cnt--; end
        default: ;
      endcase
      if (k == K_PUSH || k == K_REPL) m_mem[m_sp] = push_data;
      m_top = m_mem[m_sp];
      m_tv  = (m_cnt != 0);
      m_ovf = (k == K_OVF);
      m_unf = (k == K_UNF);
      if (m_run && !ckpt_restore && ckpt_save) begin
        m_cka[m_wptr] = m_sp; m_ckc[m_wptr] = m_cnt; m_ckv[m_wptr] = 1;
        m_wptr = (m_wptr + 1) % CK;
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      kind_t k;
      k = kind_of();
      chk("ready", ready, m_run);
      chk("state", dbg_state, m_run);
      chk("gen_addr", links_gen_addr, !m_run);
      chk("incr", links_incr, k == K_PUSH);
      chk("decr", links_decr, k == K_POP);
      chk("set_addr", links_set_addr, k == K_REST);
      if (k == K_REST) chk("addr_in", links_addr_in, m_ckv[restore_id] ? m_cka[restore_id] : 0);
      chk("ckpt_id", ckpt_id, m_wptr);
      chk("top_valid", top_valid, m_tv);
      if (m_tv) chk("top_data", top_data, m_top);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
    end else begin
      chk("rst_outs", {ready, top_valid, overflow, underflow, links_incr, links_decr,
                       links_gen_addr, links_set_addr}, 0);
      chk("rst_top", top_data, 0);
    end
  end

  task automatic drive(input bit p, input logic [W-1:0] d, input bit o,
                       input bit s, input bit r, input logic [CW-1:0] rid);
    @(posedge clk); #1;
    push = p; push_data = d; pop = o; ckpt_save = s; ckpt_restore = r; restore_id = rid;
  endtask

  task automatic idle(); drive(0, '0, 0, 0, 0, '0); endtask

  initial begin
    logic [W-1:0] rv;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("lit_init_gen", links_gen_addr, 1);
    chk("lit_init_ready", ready, 0);
    idle(); @(negedge clk);
    chk("lit_run_ready", ready, 1);
    chk("lit_run_tv", top_valid, 0);

    // push three, pop three
    drive(1, 16'h100, 0, 0, 0, 0);
    drive(1, 16'h200, 0, 0, 0, 0);
    drive(1, 16'h300, 0, 0, 0, 0);
    idle(); @(negedge clk);
    chk("lit_top_300", top_data, 16'h300);
    drive(0, 0, 1, 0, 0, 0); @(negedge clk);
    chk("lit_pop_decr", links_decr, 1);
    drive(0, 0, 1, 0, 0, 0); @(negedge clk);
    chk("lit_top_200", top_data, 16'h200);
    drive(0, 0, 1, 0, 0, 0); @(negedge clk);
    chk("lit_top_100", top_data, 16'h100);
    idle(); @(negedge clk);
    chk("lit_empty_tv", top_valid, 0);

    // underflow
    drive(0, 0, 1, 0, 0, 0); @(negedge clk);
    chk("lit_unf_decr", links_decr, 0);
    idle(); @(negedge clk);
    chk("lit_unf_pulse", underflow, 1);
    idle(); @(negedge clk);
    chk("lit_unf_clear", underflow, 0);
    chk("lit_unf_tv", top_valid, 0);

    // checkpoint then restore
    drive(1, 16'hA, 0, 0, 0, 0);
    drive(1, 16'hB, 0, 1, 0, 0); @(negedge clk);
    chk("lit_ckpt_id0", ckpt_id, 0);
    drive(1, 16'hC, 0, 0, 0, 0);
    drive(1, 16'hD, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0); @(negedge clk);
    chk("lit_rest_set", links_set_addr, 1);
    chk("lit_rest_addr", links_addr_in, 2);
    idle(); @(negedge clk);
    chk("lit_rest_top", top_data, 16'hB);
    chk("lit_rest_cnt", m_cnt, 2);

    // replace top at count 3
    drive(1, 16'h77, 0, 0, 0, 0);
    drive(1, 16'h55, 1, 0, 0, 0); @(negedge clk);
    chk("lit_repl_cmd", {links_incr, links_decr}, 0);
    idle(); @(negedge clk);
    chk("lit_repl_top", top_data, 16'h55);
    chk("lit_repl_cnt", m_cnt, 3);
    drive(0, 0, 1, 0, 0, 0);
    idle(); @(negedge clk);
    chk("lit_after_repl_pop", top_data, 16'hB);

    // links_full drop
    links_full = 1'b1;
    drive(1, 16'hEE, 0, 0, 0, 0); @(negedge clk);
    chk("lit_full_incr", links_incr, 0);
    idle(); @(negedge clk);
    chk("lit_full_ovf", overflow, 1);
    links_full = 1'b0;

    // fill to DEPTH then one more push, then drain past empty
    for (int i = 0; i < DEPTH - 2; i++) begin
      rv = W'($urandom_range(1, 16'hFFFF));
      drive(1, rv, 0, 0, 0, 0);
    end
    drive(1, 16'h1234, 0, 0, 0, 0); @(negedge clk);
    chk("lit_depth_incr", links_incr, 0);
    idle(); @(negedge clk);
    chk("lit_depth_ovf", overflow, 1);
    for (int i = 0; i < DEPTH + 1; i++) drive(0, 0, 1, 0, 0, 0);
    idle(); @(negedge clk);
    chk("lit_drain_unf", underflow, 1);

    // checkpoint ring wrap
    drive(1, 16'h11, 0, 0, 0, 0);
    for (int i = 0; i < CK; i++) drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("lit_wrap_id", ckpt_id, 0);
    drive(1, 16'h22, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0); @(negedge clk);
    chk("lit_wrap_addr", links_addr_in, 1);
    idle(); @(negedge clk);
    chk("lit_wrap_top", top_data, 16'h11);

    // reset in the middle of a push
    drive(1, 16'h99, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("lit_mid_rst", {ready, links_incr, links_gen_addr, top_valid}, 0);
    chk("lit_mid_rst_top", top_data, 0);
    push = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("lit_rerun_gen", links_gen_addr, 1);

    // restore of a slot that was never saved since reset
    drive(0, 0, 0, 0, 1, 2); @(negedge clk);
    chk("lit_inv_set", links_set_addr, 1);
    chk("lit_inv_addr", links_addr_in, 0);
    idle(); @(negedge clk);
    chk("lit_inv_tv", top_valid, 0);
    idle(); idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
